// File: rtl/game_pkg.sv
// Shared encodings for the game flow controller: display cell indices, FSM states
// and a BCD helper for elaborating the countdown reload value.
package game_pkg;

   localparam logic [4:0] DARK        = 5'd31;
   localparam logic [4:0] DIGIT_BASE  = 5'd0;
   localparam logic [4:0] PLAYER_BASE = 5'd10;
   localparam logic [4:0] BULLET_BASE = 5'd13;
   localparam logic [4:0] BUBBLE_BASE = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Two-digit BCD of a small non-negative integer (0..99).
   function automatic logic [7:0] bcd_of(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between the top-level game module (master) and the
// flow controller (slave).
interface game_flow_ctrl_if
   import game_pkg::*;
#(
   parameter int SCORE_DIGITS = 4,
   parameter int COLS         = 8,
   parameter int CELL_W       = 5
);
   logic                       en;
   logic                       pause;
   logic                       hit;
   logic [3:0]                 hit_pts;
   state_t                     state;
   logic                       playing;
   logic                       tick;
   logic                       finished;
   logic [7:0]                 time_bcd;
   logic [4*SCORE_DIGITS-1:0]  score_bcd;
   logic [COLS*CELL_W-1:0]     status_row;

   modport master (
      output en, pause, hit, hit_pts,
      input  state, playing, tick, finished, time_bcd, score_bcd, status_row
   );

   modport slave (
      input  en, pause, hit, hit_pts,
      output state, playing, tick, finished, time_bcd, score_bcd, status_row
   );
endinterface

// File: rtl/bcd_digit.sv
// One registered BCD digit: add or subtract (val + ci) with carry/borrow out,
// synchronous load and force-to-9 saturation.
module bcd_digit #(
   parameter logic [3:0] RST_VAL = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld,
   input  logic [3:0] ld_val,
   input  logic       en,
   input  logic       dn,
   input  logic       sat,
   input  logic [3:0] val,
   input  logic       ci,
   output logic [3:0] q,
   output logic       co
);
   logic [4:0] raw;
   logic [3:0] nx;

   // co is a borrow when dn=1, a decimal carry otherwise
   always_comb begin
      if (dn) begin
         raw = {1'b0, q} - {1'b0, val} - {4'b0, ci};
         co  = raw[4];
         nx  = co ? raw[3:0] + 4'd10 : raw[3:0];
      end else begin
         raw = {1'b0, q} + {1'b0, val} + {4'b0, ci};
         co  = (raw > 5'd9);
         nx  = co ? raw[3:0] - 4'd10 : raw[3:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)      q <= RST_VAL;
      else if (ld)  q <= ld_val;
      else if (sat) q <= 4'd9;
      else if (en)  q <= nx;
   end
endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: IDLE/PLAY/PAUSE/FINISH sequencing, tick divider,
// BCD countdown, saturating BCD score and status-row composition.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int GAME_TICKS   = 60,
   parameter int SCORE_DIGITS = 4,
   parameter int COLS         = 8,
   parameter int CELL_W       = 5
) (
   input logic             clk,
   input logic             rst,
   game_flow_ctrl_if.slave bus
);
   localparam int         DIV_W  = $clog2(TICK_DIV);
   localparam logic [7:0] T_LOAD = bcd_of(GAME_TICKS);

   state_t                       state;
   logic [DIV_W-1:0]             div;
   logic                         en_q, pause_q;
   logic                         tick_r, playing_r, finished_r;
   logic                         en_req, pause_req, wrap, last_tick, hit_ok;
   logic [3:0]                   pts;
   logic [1:0][3:0]              t_q;
   logic [2:0]                   t_bo;
   logic [SCORE_DIGITS-1:0][3:0] s_q;
   logic [SCORE_DIGITS:0]        s_co;
   logic [COLS-1:0][CELL_W-1:0]  row;
   logic                         lead;

   assign en_req    = bus.en & ~en_q;
   assign pause_req = bus.pause & ~pause_q;
   assign wrap      = (state == ST_PLAY) && !en_req && (div == DIV_W'(TICK_DIV - 1));
   assign last_tick = wrap && (t_q == 8'h01);
   // a hit in the same cycle as a restart is lost with the old game
   assign hit_ok    = bus.hit && (state == ST_PLAY) && !en_req;
   assign pts       = (bus.hit_pts > 4'd9) ? 4'd9 : bus.hit_pts;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         div        <= '0;
         en_q       <= 1'b0;
         pause_q    <= 1'b0;
         tick_r     <= 1'b0;
         playing_r  <= 1'b0;
         finished_r <= 1'b0;
      end else begin
         en_q    <= bus.en;
         pause_q <= bus.pause;
         tick_r  <= wrap;
         if (en_req) begin
            state      <= ST_PLAY;
            playing_r  <= 1'b1;
            finished_r <= 1'b0;
            div        <= '0;
         end else begin
            case (state)
               ST_PLAY: begin
                  if (wrap) begin
                     div <= '0;
                     if (last_tick) begin
                        state      <= ST_FINISH;
                        playing_r  <= 1'b0;
                        finished_r <= 1'b1;
                     end else if (pause_req) begin
                        state     <= ST_PAUSE;
                        playing_r <= 1'b0;
                     end
                  end else if (pause_req) begin
                     state     <= ST_PAUSE;
                     playing_r <= 1'b0;
                  end else begin
                     div <= div + 1'b1;
                  end
               end
               ST_PAUSE: begin
                  if (pause_req) begin
                     state     <= ST_PLAY;
                     playing_r <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Countdown: ones digit borrows into tens on each tick
   assign t_bo[0] = wrap;
   for (genvar i = 0; i < 2; i++) begin : g_time
      bcd_digit #(.RST_VAL(T_LOAD[i*4 +: 4])) u_dig (
         .clk(clk), .rst(rst), .ld(en_req), .ld_val(T_LOAD[i*4 +: 4]),
         .en(1'b1), .dn(1'b1), .sat(1'b0), .val(4'd0), .ci(t_bo[i]),
         .q(t_q[i]), .co(t_bo[i+1])
      );
   end

   // Score: pts enters the ones digit, carries ripple up; a carry out of the
   // top digit pins every digit at 9 instead of wrapping
   assign s_co[0] = 1'b0;
   for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_score
      bcd_digit #(.RST_VAL(4'd0)) u_dig (
         .clk(clk), .rst(rst), .ld(en_req), .ld_val(4'd0),
         .en(hit_ok), .dn(1'b0), .sat(hit_ok && s_co[SCORE_DIGITS]),
         .val((i == 0) ? pts : 4'd0), .ci(s_co[i]),
         .q(s_q[i]), .co(s_co[i+1])
      );
   end

   // Row index COLS-1 is cell 0; score digit k (0 = ones) lands in row[k]
   always_comb begin
      lead = 1'b1;
      for (int c = 0; c < COLS; c++) row[c] = CELL_W'(DARK);
      if (state != ST_IDLE) begin
         row[COLS-1] = CELL_W'(DIGIT_BASE) + CELL_W'(t_q[1]);
         row[COLS-2] = CELL_W'(DIGIT_BASE) + CELL_W'(t_q[0]);
         for (int k = SCORE_DIGITS - 1; k >= 0; k--) begin
            lead   = lead && (s_q[k] == 4'd0);
            row[k] = (lead && k != 0) ? CELL_W'(DARK)
                                      : CELL_W'(DIGIT_BASE) + CELL_W'(s_q[k]);
         end
      end
   end

   assign bus.state      = state;
   assign bus.playing    = playing_r;
   assign bus.finished   = finished_r;
   assign bus.tick       = tick_r;
   assign bus.time_bcd   = t_q;
   assign bus.score_bcd  = s_q;
   assign bus.status_row = row;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: integer-level game model checked every cycle,
// directed scenarios with literal expectations, and a second instance for saturation.
module tb_game_flow_ctrl;
   localparam int TD = 4;
   localparam int GT = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   game_flow_ctrl_if #(.SCORE_DIGITS(4), .COLS(8), .CELL_W(5)) a ();
   game_flow_ctrl_if #(.SCORE_DIGITS(4), .COLS(8), .CELL_W(5)) b ();

   game_flow_ctrl #(.TICK_DIV(TD), .GAME_TICKS(GT), .SCORE_DIGITS(4), .COLS(8), .CELL_W(5))
      dut_a (.clk(clk), .rst(rst), .bus(a));
   game_flow_ctrl #(.TICK_DIV(2000), .GAME_TICKS(GT), .SCORE_DIGITS(4), .COLS(8), .CELL_W(5))
      dut_b (.clk(clk), .rst(rst), .bus(b));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] bcd4(input int v);
      logic [15:0] r;
      int          x;
      x = v;
      for (int j = 0; j < 4; j++) begin
         r[j*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Cell list from integers: time digits first, score right-aligned without leading zeros
   function automatic logic [39:0] row_of(input int mode, input int rem, input int sc);
      logic [4:0]  c [8];
      logic [39:0] r;
      int          p;
      for (int i = 0; i < 8; i++) c[i] = 5'd31;
      if (mode != 0) begin
         c[0] = 5'(rem / 10);
         c[1] = 5'(rem % 10);
         p = 1;
         for (int j = 0; j < 4; j++) begin
            if (j == 0 || sc >= p) c[7-j] = 5'((sc / p) % 10);
            p = p * 10;
         end
      end
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[34:0], c[i]};
      return r;
   endfunction

   // Model: mode 0 idle, 1 play, 2 pause, 3 finish; ticks counted in play cycles
   int m_mode, m_cnt, m_rem, m_score;
   bit m_tick, m_en_prev, m_pz_prev, mdl_on = 1'b0;

   always @(posedge clk) begin
      bit en_e, pz_e;
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_rem = GT; m_score = 0;
         m_tick = 0; m_en_prev = 0; m_pz_prev = 0; mdl_on = 1'b1;
      end else begin
         en_e   = a.en && !m_en_prev;
         pz_e   = a.pause && !m_pz_prev;
         m_tick = 0;
         if (en_e) begin
            m_mode = 1; m_cnt = 0; m_rem = GT; m_score = 0;
         end else if (m_mode == 1) begin
            if (a.hit) begin
               m_score = m_score + ((a.hit_pts > 9) ? 9 : int'(a.hit_pts));
               if (m_score > 9999) m_score = 9999;
            end
            if (pz_e && m_cnt != TD - 1) m_mode = 2;
            else begin
               m_cnt++;
               if (m_cnt == TD) begin
                  m_cnt  = 0;
                  m_tick = 1;
                  m_rem--;
                  if (m_rem == 0) m_mode = 3;
                  else if (pz_e) m_mode = 2;
               end
            end
         end else if (m_mode == 2 && pz_e) begin
            m_mode = 1;
         end
         m_en_prev = a.en;
         m_pz_prev = a.pause;
      end
   end

   always @(negedge clk) begin
      if (!rst && mdl_on) begin
         chk("state",    a.state,      64'(m_mode));
         chk("playing",  a.playing,    64'(m_mode == 1));
         chk("finished", a.finished,   64'(m_mode == 3));
         chk("tick",     a.tick,       64'(m_tick));
         chk("time",     a.time_bcd,   64'(bcd2(m_rem)));
         chk("score",    a.score_bcd,  64'(bcd4(m_score)));
         chk("row",      a.status_row, 64'(row_of(m_mode, m_rem, m_score)));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [39:0] dark_row, row_lit;
      dark_row = {8{5'd31}};
      a.en = 0; a.pause = 0; a.hit = 0; a.hit_pts = 0;
      b.en = 0; b.pause = 0; b.hit = 0; b.hit_pts = 0;
      cyc(2);
      rst = 0;
      chk("rst_state", a.state, 64'd0);
      chk("rst_time",  a.time_bcd, 64'h12);
      chk("rst_score", a.score_bcd, 64'h0);
      chk("rst_row",   a.status_row, 64'(dark_row));

      // en held 20 cycles: one start, first tick 4 cycles in
      a.en = 1;
      cyc(1); chk("start_state", a.state, 64'd1);
      cyc(3); chk("pre_tick", a.tick, 64'd0);
      cyc(1); chk("first_tick", a.tick, 64'd1);
      chk("first_time", a.time_bcd, 64'h11);
      cyc(8); chk("borrow_09", a.time_bcd, 64'h09);
      cyc(7); chk("held_en_time", a.time_bcd, 64'h08);
      a.en = 0;

      a.hit = 1; a.hit_pts = 7; cyc(1);
      a.hit_pts = 5; cyc(1);
      a.hit = 0;
      chk("score_12", a.score_bcd, 64'h0012);
      row_lit = {5'd0, 5'd7, 5'd31, 5'd31, 5'd31, 5'd31, 5'd1, 5'd2};
      chk("row_lit", a.status_row, 64'(row_lit));

      // hit during the final tick cycle still counts
      cyc(26);
      a.hit = 1; a.hit_pts = 3; cyc(1);
      chk("fin_state", a.state, 64'd3);
      chk("fin_flag",  a.finished, 64'd1);
      chk("fin_time",  a.time_bcd, 64'h00);
      chk("fin_score", a.score_bcd, 64'h0015);
      a.hit_pts = 9; a.pause = 1; cyc(10);
      chk("fin_hold_state", a.state, 64'd3);
      chk("fin_hold_score", a.score_bcd, 64'h0015);
      a.hit = 0; a.pause = 0;

      // restart from FINISH, pause at divider 2
      a.en = 1; cyc(1);
      chk("restart_time",  a.time_bcd, 64'h12);
      chk("restart_score", a.score_bcd, 64'h0);
      a.en = 0;
      cyc(2); a.pause = 1; cyc(1);
      chk("paused", a.state, 64'd2);
      a.hit = 1; a.hit_pts = 4; cyc(50);
      chk("pause_time",  a.time_bcd, 64'h12);
      chk("pause_score", a.score_bcd, 64'h0);
      a.hit = 0; a.pause = 0; cyc(1);
      a.pause = 1; cyc(1);
      chk("resume", a.state, 64'd1);
      cyc(1); chk("resume_no_tick", a.tick, 64'd0);
      cyc(1); chk("resume_tick", a.tick, 64'd1);
      chk("resume_time", a.time_bcd, 64'h11);
      a.pause = 0;

      a.hit = 1; a.hit_pts = 12; cyc(1);
      chk("clamp_9", a.score_bcd, 64'h0009);
      a.en = 1; a.hit_pts = 5; cyc(1);
      chk("en_hit_score", a.score_bcd, 64'h0);
      chk("en_hit_time",  a.time_bcd, 64'h12);
      a.en = 0; a.hit = 0;

      cyc(3); rst = 1; cyc(1);
      chk("midrst_state", a.state, 64'd0);
      chk("midrst_row",   a.status_row, 64'(dark_row));
      rst = 0;
      a.hit = 1; a.hit_pts = 3; cyc(3);
      chk("idle_hit", a.score_bcd, 64'h0);
      a.hit = 0;

      // saturation on the slow-tick instance
      b.en = 1; cyc(1); b.en = 0;
      b.hit = 1; b.hit_pts = 9; cyc(1110);
      chk("b_9990", b.score_bcd, 64'h9990);
      b.hit_pts = 5; cyc(1);
      chk("b_9995", b.score_bcd, 64'h9995);
      b.hit_pts = 9; cyc(1);
      chk("b_sat", b.score_bcd, 64'h9999);
      cyc(3);
      chk("b_sat_hold", b.score_bcd, 64'h9999);
      row_lit = {5'd1, 5'd2, 5'd31, 5'd31, 5'd9, 5'd9, 5'd9, 5'd9};
      chk("b_row", b.status_row, 64'(row_lit));
      b.hit = 0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
